ama_riscv_uart: RTL and testbench
=================================

// Module: ama_riscv_uart
// PURPOSE
//  MMIO UART peripheral behind the DMEM/MMIO decode (addr[31:28]==MMIO_RANGE); the core's load/store path is its sole client.
//  Exposes 3 word regs {CTRL, RX, TX} (UART_SIZE bytes). Serializes TX bytes 8N1, deserializes RX bytes 8N1.
//  Fixed baud; no FIFOs: 1-byte TX holding/shift reg, 1-byte RX data reg.
// PARAMETERS
//  CLOCK_FREQ  100_000_000  core clock in Hz
//  BAUD_RATE   BR_115200    uart_baud_rate_t; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide)
//  Elaboration check: CLKS_PER_BIT >= 4, else $fatal.
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous active-high reset
//  req_valid  in   1   MMIO request
//  req_ready  out  1   tied 1; every request accepted
//  req_rtype  in   1   dmem_rtype_t: DMEM_READ / DMEM_WRITE
//  req_addr   in   4   byte offset in UART window; word index = req_addr[3:2] (uart_addr_t)
//  req_wdata  in   32  write data; TX uses [7:0]
//  rsp_valid  out  1   read data valid, exactly 1 cycle after an accepted read
//  rsp_data   out  32  read data
//  serial_in  in   1   async RX line, idle high
//  serial_out out  1   TX line, idle high
// BEHAVIOUR
//  Reset: serial_out=1, rsp_valid=0, rsp_data=0, tx_ready=1, rx_valid=0, rx_byte=0, both FSMs IDLE, counters 0.
//  Reset mid-frame aborts: serial_out=1 after the reset edge; partial RX byte discarded.
//  Reads (1-cycle latency, registered):
//   CTRL -> {30'b0, rx_valid, tx_ready} (uart_ctrl_t); RX -> {24'b0, rx_byte}, clears rx_valid;
//   TX or index 3 -> 32'h0. Write requests never raise rsp_valid.
//  Writes: TX with tx_ready=1 -> latch wdata[7:0], tx_ready=0 next cycle, frame starts next cycle.
//   TX while tx_ready=0 -> dropped, no side effect. Writes to CTRL/RX/index 3 ignored.
//  TX FSM IDLE->START->DATA->STOP->IDLE; each bit exactly CLKS_PER_BIT cycles.
//   START drives 0; DATA sends bits LSB first (3-bit index); STOP drives 1.
//   tx_ready=1 in the cycle after STOP ends: 10*CLKS_PER_BIT cycles after frame start.
//   A write in that same cycle starts back-to-back frame.
//  RX: serial_in through 2-FF sync (reset to 1); FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: synced low -> START, wait CLKS_PER_BIT/2 and resample.
//   Resample high -> false start, back to IDLE. Otherwise sample mid-bit every CLKS_PER_BIT: 8 data LSB first, then stop.
//   Stop==1 -> rx_byte<=shift, rx_valid<=1. Stop==0 -> framing error, byte discarded, no flag.
//   Overrun (rx_valid already 1): rx_byte overwritten, newest wins, rx_valid stays 1.
//   RX read clear and new-byte set in the same cycle: set wins; read returns the old byte.
//  Baud counters: width $clog2(CLKS_PER_BIT); count 0..CLKS_PER_BIT-1 then wrap, no saturation.
//  TX and RX fully independent; loopback (serial_out->serial_in) is legal.
// STRUCTURE
//  Shared defines: add uart_fsm_t {UART_IDLE, UART_START, UART_DATA, UART_STOP}.
//   Reuse uart_ctrl_t, uart_addr_t, uart_baud_rate_t, dmem_rtype_t, UART_SIZE.
//  One sub-module: ama_riscv_uart_rx (sync + RX FSM; outputs byte + 1-cycle strobe).
//  TX FSM, register file and read mux stay in the top.
// TESTING (CLOCK_FREQ=7_372_800, BAUD_RATE=BR_921600 -> CLKS_PER_BIT=8)
//  1 Reset, read CTRL -> serial_out=1; rsp_valid 1 cycle later, rsp_data=32'h1.
//  2 Write TX 32'hA5 -> serial_out 0 for 8 clk, then 1,0,1,0,0,1,0,1 (8 clk each), then 1.
//    CTRL=0x0 during the frame, 0x1 after 80 clk.
//  3 Write TX 0x3C while sending 0xA5 -> line carries only the 0xA5 frame; CTRL reads 0x0 throughout.
//  4 Drive serial_in frame 0x5A -> CTRL=0x3; read RX -> 32'h5A; next CTRL read -> 0x1.
//  5 serial_in low for 2 clk only -> no rx_valid. Frame 0x77 with stop bit 0 -> rx_valid stays 0.
//  6 Frames 0x11 then 0x22 unread -> RX reads 0x22.
//    Loopback write 0xC3 -> RX reads 0xC3.
//    rst asserted mid-TX -> serial_out=1 after the reset edge, CTRL=0x1.

Source files
------------

// File: rtl/ama_riscv_uart_pkg.sv
// ama_riscv_uart_pkg: shared types and constants for the MMIO UART
package ama_riscv_uart_pkg;
  localparam logic [3:0] MMIO_RANGE = 4'hF;
  localparam int UART_SIZE = 12;
  typedef enum logic {DMEM_READ, DMEM_WRITE} dmem_rtype_t;
  typedef enum logic [1:0] {UART_CTRL, UART_RX, UART_TX} uart_addr_t;
  typedef struct packed {
    logic rx_valid;
    logic tx_ready;
  } uart_ctrl_t;
  typedef enum logic [31:0] {
    BR_9600   = 32'd9600,
    BR_19200  = 32'd19200,
    BR_38400  = 32'd38400,
    BR_57600  = 32'd57600,
    BR_115200 = 32'd115200,
    BR_230400 = 32'd230400,
    BR_460800 = 32'd460800,
    BR_921600 = 32'd921600
  } uart_baud_rate_t;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_fsm_t;
  function automatic int clks_per_bit(input int freq, input uart_baud_rate_t br);
    return freq / int'(br);
  endfunction
endpackage

// File: rtl/ama_riscv_uart_if.sv
// ama_riscv_uart_if: MMIO request/response bus between the load/store path and the UART
interface ama_riscv_uart_if;
  import ama_riscv_uart_pkg::*;
  logic        req_valid;
  logic        req_ready;
  dmem_rtype_t req_rtype;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master (
    output req_valid, req_rtype, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_rtype, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ama_riscv_uart_rx.sv
// ama_riscv_uart_rx: 2-FF synchronizer and 8N1 receiver; strobe_o pulses one cycle with byte_o valid
module ama_riscv_uart_rx
  import ama_riscv_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_i,
  output logic [7:0] byte_o,
  output logic       strobe_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] sync_q;
  uart_fsm_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic rx;
  assign rx = sync_q[1];
  assign byte_o = shift_q;
  assign strobe_o = state_q == UART_STOP && cnt_q == LAST && rx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], serial_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q == LAST ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = UART_START;
      end
      UART_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx ? UART_IDLE : UART_DATA;
      end
      UART_DATA: if (cnt_q == LAST) begin
        shift_d = {rx, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = UART_STOP;
      end
      UART_STOP: if (cnt_q == LAST) state_d = UART_IDLE;
      default: state_d = UART_IDLE;
    endcase
  end
endmodule

// File: rtl/ama_riscv_uart.sv
// ama_riscv_uart: MMIO UART with CTRL/RX/TX word registers, 8N1 transmitter and receiver
module ama_riscv_uart
  import ama_riscv_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE = BR_115200
) (
  input  logic            clk,
  input  logic            rst,
  ama_riscv_uart_if.slave bus,
  input  logic            serial_in,
  output logic            serial_out
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $fatal(1, "ama_riscv_uart: CLKS_PER_BIT must be >= 4");
  end
  uart_fsm_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic serial_out_q, serial_out_d;
  logic rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic rsp_valid_q;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0] rx_shift;
  logic rx_strobe, tx_ready, rd, rd_rx, wr_tx, unused_bits;
  uart_ctrl_t ctrl;
  ama_riscv_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .serial_i (serial_in),
    .byte_o   (rx_shift),
    .strobe_o (rx_strobe)
  );
  assign unused_bits = ^{bus.req_wdata[31:8], bus.req_addr[1:0]};
  assign tx_ready = tx_state_q == UART_IDLE;
  assign rd = bus.req_valid && bus.req_rtype == DMEM_READ;
  assign rd_rx = rd && bus.req_addr[3:2] == UART_RX;
  assign wr_tx = bus.req_valid && bus.req_rtype == DMEM_WRITE && bus.req_addr[3:2] == UART_TX && tx_ready;
  assign ctrl = '{rx_valid: rx_valid_q, tx_ready: tx_ready};
  // a new byte in the same cycle as an RX read keeps the flag set
  assign rx_valid_d = rx_strobe || (rx_valid_q && !rd_rx);
  assign rx_byte_d = rx_strobe ? rx_shift : rx_byte_q;
  assign rsp_data_d = !rd ? '0 : bus.req_addr[3:2] == UART_CTRL ? {30'b0, ctrl} : rd_rx ? {24'b0, rx_byte_q} : '0;
  assign bus.req_ready = 1'b1;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
  assign serial_out = serial_out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q   <= UART_IDLE;
      tx_cnt_q     <= '0;
      tx_idx_q     <= '0;
      tx_data_q    <= '0;
      serial_out_q <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_data_q    <= tx_data_d;
      serial_out_q <= serial_out_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      rsp_valid_q  <= rd;
      rsp_data_q   <= rsp_data_d;
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q == LAST ? '0 : tx_cnt_q + CW'(1);
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      UART_IDLE: begin
        tx_cnt_d = '0;
        if (wr_tx) begin
          tx_state_d = UART_START;
          tx_data_d  = bus.req_wdata[7:0];
        end
      end
      UART_START: if (tx_cnt_q == LAST) begin
        tx_state_d = UART_DATA;
        tx_idx_d   = '0;
      end
      UART_DATA: if (tx_cnt_q == LAST) begin
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = UART_STOP;
      end
      UART_STOP: if (tx_cnt_q == LAST) tx_state_d = UART_IDLE;
      default: tx_state_d = UART_IDLE;
    endcase
    // registered line level follows the next state so the frame starts the cycle after the write
    serial_out_d = tx_state_d == UART_START ? 1'b0 : tx_state_d == UART_DATA ? tx_data_d[tx_idx_d] : 1'b1;
  end
endmodule

// File: tb/tb_ama_riscv_uart.sv
// tb_ama_riscv_uart: scoreboard-driven bench for the MMIO UART at 8 clocks per bit
module tb_ama_riscv_uart;
  import ama_riscv_uart_pkg::*;
  logic clk, rst, sin, loop, serial_out, dut_in;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  ama_riscv_uart_if bus();
  assign dut_in = loop ? serial_out : sin;
  ama_riscv_uart #(.CLOCK_FREQ(7_372_800), .BAUD_RATE(BR_921600)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .serial_in  (dut_in),
    .serial_out (serial_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 data=%h with nothing outstanding", bus.rsp_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (bus.rsp_data !== e) begin
          errors++;
          $display("FAIL %s: rsp_data got %h expected %h", n, bus.rsp_data, e);
        end
      end
    end
  end
  function automatic logic tx_bit(input logic [7:0] b, input int j);
    return j < 8 ? 1'b0 : j < 72 ? b[(j - 8) / 8] : 1'b1;
  endfunction
  task automatic drive(input dmem_rtype_t t, input logic [3:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_rtype = t;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask
  task automatic push(input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    drive(DMEM_READ, a, 32'h0);
    push(e, n);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    drive(DMEM_WRITE, a, d);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rx_send(input logic [7:0] b, input logic stop);
    sin = 1'b0;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      sin = b[i];
      idle(8);
    end
    sin = stop;
    idle(8);
    sin = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks += 3;
    if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial_out: got %b expected 1", serial_out); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
    rst = 1'b0;
    rd(4'h0, 32'h1, "reset_ctrl");
    idle(1);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain: %0d responses outstanding, expected 0", exp_q.size()); end
  endtask
  task automatic test_regs;
    rd(4'h8, 32'h0, "read_tx_reg");
    rd(4'hC, 32'h0, "read_idx3");
    rd(4'h4, 32'h0, "read_rx_after_reset");
    wr(4'h0, 32'hFFFF_FFFF);
    wr(4'h4, 32'hFF);
    wr(4'hC, 32'hFF);
    idle(2);
    rd(4'h0, 32'h1, "ctrl_after_ignored_writes");
    idle(1);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL regs_drain: %0d responses outstanding, expected 0", exp_q.size()); end
  endtask
  task automatic test_tx;
    wr(4'h8, 32'hA5);
    for (int j = 0; j < 80; j++) begin
      checks++;
      if (serial_out !== tx_bit(8'hA5, j)) begin
        errors++;
        $display("FAIL tx_a5_bit cycle %0d: serial_out got %b expected %b", j, serial_out, tx_bit(8'hA5, j));
      end
      bus.req_valid = 1'b0;
      if (j == 10) drive(DMEM_WRITE, 4'h8, 32'h3C);
      if (j == 20 || j == 60 || j == 79) begin
        drive(DMEM_READ, 4'h0, 32'h0);
        push(32'h0, "tx_busy_ctrl");
      end
      @(negedge clk);
    end
    rd(4'h0, 32'h1, "tx_done_ctrl");
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (serial_out !== 1'b1) begin errors++; $display("FAIL tx_dropped_write cycle %0d: serial_out got %b expected 1", j, serial_out); end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tx_drain: %0d responses outstanding, expected 0", exp_q.size()); end
  endtask
  task automatic test_back_to_back;
    wr(4'h8, 32'h0F);
    for (int j = 0; j < 80; j++) begin
      checks++;
      if (serial_out !== tx_bit(8'h0F, j)) begin errors++; $display("FAIL b2b_first cycle %0d: got %b expected %b", j, serial_out, tx_bit(8'h0F, j)); end
      @(negedge clk);
    end
    checks++;
    if (serial_out !== 1'b1) begin errors++; $display("FAIL b2b_gap: serial_out got %b expected 1", serial_out); end
    wr(4'h8, 32'hF0);
    for (int j = 0; j < 80; j++) begin
      checks++;
      if (serial_out !== tx_bit(8'hF0, j)) begin errors++; $display("FAIL b2b_second cycle %0d: got %b expected %b", j, serial_out, tx_bit(8'hF0, j)); end
      @(negedge clk);
    end
    idle(2);
  endtask
  task automatic test_rx;
    rx_send(8'h5A, 1'b1);
    idle(4);
    rd(4'h0, 32'h3, "rx_ctrl_valid");
    rd(4'h4, 32'h5A, "rx_byte");
    rd(4'h0, 32'h1, "rx_ctrl_cleared");
    idle(1);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rx_drain: %0d responses outstanding, expected 0", exp_q.size()); end
  endtask
  task automatic test_rx_errors;
    sin = 1'b0;
    idle(2);
    sin = 1'b1;
    idle(20);
    rd(4'h0, 32'h1, "false_start_ctrl");
    rx_send(8'h77, 1'b0);
    idle(30);
    rd(4'h0, 32'h1, "framing_err_ctrl");
    rd(4'h4, 32'h5A, "framing_err_byte_kept");
    idle(1);
  endtask
  task automatic test_overrun;
    rx_send(8'h11, 1'b1);
    idle(2);
    rx_send(8'h22, 1'b1);
    idle(4);
    rd(4'h0, 32'h3, "overrun_ctrl");
    rd(4'h4, 32'h22, "overrun_newest");
    rd(4'h0, 32'h1, "overrun_cleared");
    idle(1);
  endtask
  task automatic test_loopback;
    loop = 1'b1;
    idle(2);
    wr(4'h8, 32'hC3);
    idle(100);
    rd(4'h0, 32'h3, "loopback_ctrl");
    rd(4'h4, 32'hC3, "loopback_byte");
    loop = 1'b0;
    idle(2);
  endtask
  task automatic test_reset_mid_tx;
    wr(4'h8, 32'h55);
    idle(18);
    checks++;
    if (serial_out !== 1'b0) begin errors++; $display("FAIL midtx_in_frame: serial_out got %b expected 0", serial_out); end
    rst = 1'b1;
    idle(1);
    checks++;
    if (serial_out !== 1'b1) begin errors++; $display("FAIL midtx_reset_line: serial_out got %b expected 1", serial_out); end
    rst = 1'b0;
    rd(4'h0, 32'h1, "midtx_reset_ctrl");
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (serial_out !== 1'b1) begin errors++; $display("FAIL midtx_idle cycle %0d: got %b expected 1", j, serial_out); end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: %0d responses outstanding, expected 0", exp_q.size()); end
  endtask
  initial begin
    rst = 1'b1;
    sin = 1'b1;
    loop = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rtype = DMEM_READ;
    bus.req_addr = 4'h0;
    bus.req_wdata = 32'h0;
    @(negedge clk);
    test_reset;
    test_regs;
    test_tx;
    test_back_to_back;
    test_rx;
    test_rx_errors;
    test_overrun;
    test_loopback;
    test_reset_mid_tx;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
